// File: rtl/cache_line_fill_buffer_pkg.sv
// Shared types and helpers for the cache line fill buffer.
package cachefill_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_BUSY = 2'd1,
    FILL_FULL = 2'd2
  } fillstate_t;

  // Width of a beat index for a line of linelen bits built from beatlen-bit beats.
  function automatic int calc_idxw(input int linelen, input int beatlen);
    return $clog2(linelen / beatlen);
  endfunction

endpackage

// File: rtl/cache_line_fill_buffer_if.sv
// Bus-side and line-side signals of the cache line fill buffer.
// Optional critical-word outputs exist only when CACHE_FILL_CRITWORD_EN is defined.
interface cache_line_fill_buffer_if
  import cachefill_pkg::*;
#(
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64
);
  localparam int IDXW = calc_idxw(LINELEN, BEATLEN);

  logic               FillReq;
  logic [IDXW-1:0]    FillStartBeat;
  logic               BeatValid;
  logic [BEATLEN-1:0] BeatData;
  logic               BeatReady;
  logic               LineValid;
  logic [LINELEN-1:0] LineData;
  logic               LineAccept;
  logic               Busy;
  logic [IDXW-1:0]    FillIdx;
`ifdef CACHE_FILL_CRITWORD_EN
  logic               CritValid;
  logic [BEATLEN-1:0] CritData;
`endif

  // The fill buffer itself.
  modport slave (
    input  FillReq, FillStartBeat, BeatValid, BeatData, LineAccept,
    output BeatReady, LineValid, LineData, Busy, FillIdx
`ifdef CACHE_FILL_CRITWORD_EN
    , output CritValid, CritData
`endif
  );

  // The requester / bus / consumer side.
  modport master (
    output FillReq, FillStartBeat, BeatValid, BeatData, LineAccept,
    input  BeatReady, LineValid, LineData, Busy, FillIdx
`ifdef CACHE_FILL_CRITWORD_EN
    , input CritValid, CritData
`endif
  );

endinterface

// File: rtl/cache_line_fill_buffer_counter.sv
// Loadable wrapping beat index plus a terminal-count beat counter.
// The index picks the slot to write; the counter alone decides completion,
// so a fill that starts mid-line still ends after exactly BEATSPERLINE beats.
// o_first exists only when CACHE_FILL_CRITWORD_EN is defined.
module fill_beat_counter #(
  parameter int BEATSPERLINE = 8,
  parameter int IDXW         = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_load,
  input  logic [IDXW-1:0] i_start,
  input  logic            i_inc,
  output logic [IDXW-1:0] o_idx,
  output logic            o_last
`ifdef CACHE_FILL_CRITWORD_EN
  , output logic          o_first
`endif
);

  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] r_cnt;

  // Index and count: load restarts both, each accepted beat advances both (power-of-2 wrap).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= {IDXW{1'b0}};
      r_cnt <= {IDXW{1'b0}};
    end else if (i_load) begin
      r_idx <= i_start;
      r_cnt <= {IDXW{1'b0}};
    end else if (i_inc) begin
      r_idx <= r_idx + IDXW'(1);
      r_cnt <= r_cnt + IDXW'(1);
    end else begin
      r_idx <= r_idx;
      r_cnt <= r_cnt;
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_cnt == IDXW'(BEATSPERLINE - 1));
`ifdef CACHE_FILL_CRITWORD_EN
  assign o_first = (r_cnt == {IDXW{1'b0}});
`endif

endmodule

// File: rtl/cache_line_fill_buffer.sv
// Cache line fill buffer: assembles bus beats (critical-word-first, wrapping)
// into a full line and holds it until the consumer accepts it.
// Optional macro CACHE_FILL_CRITWORD_EN adds an early critical-word bypass.
module cache_line_fill_buffer
  import cachefill_pkg::*;
#(
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64
) (
  input logic                     clk,
  input logic                     reset_n,
  cache_line_fill_buffer_if.slave bus
);

  localparam int BEATSPERLINE = LINELEN / BEATLEN;
  localparam int IDXW         = calc_idxw(LINELEN, BEATLEN);

  fillstate_t         r_state;
  fillstate_t         w_state_nxt;
  logic               w_load;
  logic               w_beat_acc;
  logic               w_last;
  logic [IDXW-1:0]    w_idx;
  logic               r_beat_ready;
  logic               r_line_valid;
  logic               r_busy;
  logic [LINELEN-1:0] r_line;
`ifdef CACHE_FILL_CRITWORD_EN
  logic               w_first;
`endif

  // r_beat_ready mirrors state==FILL_BUSY, so this is the accepting handshake.
  assign w_beat_acc = bus.BeatValid && r_beat_ready;

  fill_beat_counter #(
    .BEATSPERLINE (BEATSPERLINE),
    .IDXW         (IDXW)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_start (bus.FillStartBeat),
    .i_inc   (w_beat_acc),
    .o_idx   (w_idx),
    .o_last  (w_last)
`ifdef CACHE_FILL_CRITWORD_EN
    , .o_first (w_first)
`endif
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FILL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and counter load; FULL with accept+request restarts without an idle bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      FILL_IDLE: begin
        if (bus.FillReq) begin
          w_state_nxt = FILL_BUSY;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = FILL_IDLE;
        end
      end
      FILL_BUSY: begin
        if (w_beat_acc && w_last) begin
          w_state_nxt = FILL_FULL;
        end else begin
          w_state_nxt = FILL_BUSY;
        end
      end
      FILL_FULL: begin
        if (bus.LineAccept) begin
          if (bus.FillReq) begin
            w_state_nxt = FILL_BUSY;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = FILL_IDLE;
          end
        end else begin
          w_state_nxt = FILL_FULL;
        end
      end
      default: begin
        w_state_nxt = FILL_IDLE;
        w_load      = 1'b0;
      end
    endcase
  end

  // Registered status outputs decoded from the next state so they track r_state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_ready <= 1'b0;
      r_line_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_beat_ready <= (w_state_nxt == FILL_BUSY);
      r_line_valid <= (w_state_nxt == FILL_FULL);
      r_busy       <= (w_state_nxt != FILL_IDLE);
    end
  end

  // Line storage: only accepted beats write, so the line is stable while FULL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line <= {LINELEN{1'b0}};
    end else if (w_beat_acc) begin
      r_line[w_idx*BEATLEN +: BEATLEN] <= bus.BeatData;
    end else begin
      r_line <= r_line;
    end
  end

  assign bus.BeatReady = r_beat_ready;
  assign bus.LineValid = r_line_valid;
  assign bus.Busy      = r_busy;
  assign bus.LineData  = r_line;
  assign bus.FillIdx   = w_idx;

`ifdef CACHE_FILL_CRITWORD_EN
  // Critical word bypass: the first accepted beat of a fill, same cycle as its handshake.
  assign bus.CritValid = w_beat_acc && w_first;
  assign bus.CritData  = bus.BeatData;
`endif

endmodule

// File: tb/tb_cache_line_fill_buffer.sv
// Directed self-checking bench for cache_line_fill_buffer (LINELEN=512, BEATLEN=64).
// Critical-word checks are compiled in when CACHE_FILL_CRITWORD_EN is defined.
module tb_cache_line_fill_buffer;

  localparam int LINELEN = 512;
  localparam int BEATLEN = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cache_line_fill_buffer_if #(.LINELEN(LINELEN), .BEATLEN(BEATLEN)) bus ();

  cache_line_fill_buffer #(.LINELEN(LINELEN), .BEATLEN(BEATLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected line when slot i holds base+i.
  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    l = 512'd0;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
    return l;
  endfunction

  task automatic start_fill(input logic [2:0] s);
    bus.FillReq       = 1'b1;
    bus.FillStartBeat = s;
    tick();
    bus.FillReq       = 1'b0;
  endtask

  // Send 8 beats starting at slot s; slot n carries base+n. Optional idle gap before each beat.
  task automatic run_beats(input string nm, input logic [63:0] base, input logic [2:0] s, input bit gaps);
    logic [2:0] slot;
    for (int k = 0; k < 8; k++) begin
      slot = s + 3'(k);
      check_eq($sformatf("%s_idx%0d", nm, k), 512'(bus.FillIdx), 512'(slot));
      check_eq($sformatf("%s_lv_early%0d", nm, k), 512'(bus.LineValid), 512'd0);
      if (gaps) begin
        bus.BeatValid = 1'b0;
        bus.BeatData  = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        check_eq($sformatf("%s_gap_idx%0d", nm, k), 512'(bus.FillIdx), 512'(slot));
      end
      bus.BeatValid = 1'b1;
      bus.BeatData  = base + 64'(slot);
`ifdef CACHE_FILL_CRITWORD_EN
      #1;
      check_eq($sformatf("%s_critv%0d", nm, k), 512'(bus.CritValid), (k == 0) ? 512'd1 : 512'd0);
      if (k == 0) check_eq($sformatf("%s_critd", nm), 512'(bus.CritData), 512'(base + 64'(slot)));
`endif
      tick();
    end
    bus.BeatValid = 1'b0;
    check_eq({nm, "_lv"},    512'(bus.LineValid), 512'd1);
    check_eq({nm, "_ready"}, 512'(bus.BeatReady), 512'd0);
    check_eq({nm, "_busy"},  512'(bus.Busy),      512'd1);
    check_eq({nm, "_line"},  bus.LineData,        mk_line(base));
  endtask

  task automatic accept_line(input string nm);
    bus.LineAccept = 1'b1;
    tick();
    bus.LineAccept = 1'b0;
    check_eq({nm, "_acc_lv"},   512'(bus.LineValid), 512'd0);
    check_eq({nm, "_acc_busy"}, 512'(bus.Busy),      512'd0);
  endtask

  initial begin
    bus.FillReq       = 1'b0;
    bus.FillStartBeat = 3'd0;
    bus.BeatValid     = 1'b0;
    bus.BeatData      = 64'd0;
    bus.LineAccept    = 1'b0;

    // Reset values
    #12;
    check_eq("rst_ready", 512'(bus.BeatReady), 512'd0);
    check_eq("rst_lv",    512'(bus.LineValid), 512'd0);
    check_eq("rst_busy",  512'(bus.Busy),      512'd0);
    check_eq("rst_idx",   512'(bus.FillIdx),   512'd0);
    check_eq("rst_line",  bus.LineData,        512'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Beats and accept in IDLE are ignored
    bus.BeatValid  = 1'b1;
    bus.BeatData   = 64'hFFFF_0000_FFFF_0000;
    bus.LineAccept = 1'b1;
    tick();
    bus.BeatValid  = 1'b0;
    bus.LineAccept = 1'b0;
    check_eq("idle_busy", 512'(bus.Busy),    512'd0);
    check_eq("idle_idx",  512'(bus.FillIdx), 512'd0);
    check_eq("idle_line", bus.LineData,      512'd0);

    // 1: start 0, beats 0..7 back-to-back
    start_fill(3'd0);
    check_eq("t1_ready", 512'(bus.BeatReady), 512'd1);
    run_beats("t1", 64'h0, 3'd0, 1'b0);
    check_eq("t1_low",  512'(bus.LineData[63:0]),    512'd0);
    check_eq("t1_high", 512'(bus.LineData[511:448]), 512'd7);

    // FULL without accept: hold line, ignore beats and requests
    bus.BeatValid = 1'b1;
    bus.BeatData  = 64'h1234_5678_9ABC_DEF0;
    bus.FillReq   = 1'b1;
    tick();
    bus.BeatValid = 1'b0;
    bus.FillReq   = 1'b0;
    check_eq("hold_lv",   512'(bus.LineValid), 512'd1);
    check_eq("hold_idx",  512'(bus.FillIdx),   512'd0);
    check_eq("hold_line", bus.LineData,        mk_line(64'h0));
    accept_line("t1");

    // 2: start 5, wrap ordering
    start_fill(3'd5);
    run_beats("t2", 64'hA0, 3'd5, 1'b0);
    accept_line("t2");

    // 3: BeatValid toggling
    start_fill(3'd0);
    run_beats("t3", 64'h30, 3'd0, 1'b1);

    // 4: accept + request together in FULL, no idle bubble
    bus.LineAccept    = 1'b1;
    bus.FillReq       = 1'b1;
    bus.FillStartBeat = 3'd2;
    tick();
    bus.LineAccept = 1'b0;
    bus.FillReq    = 1'b0;
    check_eq("t4_busy",  512'(bus.Busy),      512'd1);
    check_eq("t4_ready", 512'(bus.BeatReady), 512'd1);
    check_eq("t4_lv",    512'(bus.LineValid), 512'd0);
    check_eq("t4_idx",   512'(bus.FillIdx),   512'd2);
    bus.FillReq       = 1'b1;
    bus.FillStartBeat = 3'd6;
    tick();
    bus.FillReq = 1'b0;
    check_eq("t4_ign_idx",   512'(bus.FillIdx),   512'd2);
    check_eq("t4_ign_ready", 512'(bus.BeatReady), 512'd1);

    // 5: three beats, then reset mid-fill
    for (int k = 0; k < 3; k++) begin
      bus.BeatValid = 1'b1;
      bus.BeatData  = 64'h40 + 64'(k);
      tick();
    end
    bus.BeatValid = 1'b0;
    check_eq("t5_idx3", 512'(bus.FillIdx), 512'd5);
    reset_n = 1'b0;
    #1;
    check_eq("t5_ready", 512'(bus.BeatReady), 512'd0);
    check_eq("t5_lv",    512'(bus.LineValid), 512'd0);
    check_eq("t5_busy",  512'(bus.Busy),      512'd0);
    check_eq("t5_idx",   512'(bus.FillIdx),   512'd0);
    check_eq("t5_line",  bus.LineData,        512'd0);
    #2;
    reset_n = 1'b1;
    tick();
    start_fill(3'd1);
    run_beats("t5", 64'h50, 3'd1, 1'b0);
    accept_line("t5");

    // 6: start 3, first beat 0xDEAD (critical word when enabled)
    start_fill(3'd3);
    run_beats("t6", 64'hDEAA, 3'd3, 1'b0);
`ifdef CACHE_FILL_CRITWORD_EN
    check_eq("t6_critv_after", 512'(bus.CritValid), 512'd0);
`endif
    accept_line("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_line_fill_buffer.md
Name: cache_line_fill_buffer

Overview:
Assembles bus read beats into a full cache line during a cache miss fill. Drives the completed line to the cache data-array write path and to the sub-cacheline word mux, so a missed fetch or load can be returned without an SRAM re-read. Supports critical-word-first wrap ordering, with a valid/ready handshake on both the bus side and the line side.

Parameters:
LINELEN, 512, cache line width in bits; power of 2.
BEATLEN, 64, bus beat width in bits; power of 2; LINELEN/BEATLEN >= 2.
BEATSPERLINE (localparam), LINELEN/BEATLEN, number of beats per line.
IDXW (localparam), $clog2(BEATSPERLINE), beat index width.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
FillReq  in  1  start a fill; sampled only in IDLE, or in FULL together with LineAccept
FillStartBeat  in  IDXW  first (critical) beat index, sampled with an accepted FillReq
BeatValid  in  1  bus beat present
BeatData  in  BEATLEN  bus beat data
BeatReady  out  1  buffer accepts the beat this cycle
LineValid  out  1  complete line held
LineData  out  LINELEN  assembled line, beat i at bits [i*BEATLEN +: BEATLEN]
LineAccept  in  1  consumer takes the line
Busy  out  1  state != IDLE
FillIdx  out  IDXW  index of the next beat to be written

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, BeatReady=0, LineValid=0, Busy=0, FillIdx=0, beat counter=0, LineData=0.
- States:
  - IDLE -> FILL on FillReq. Latch FillIdx=FillStartBeat; counter=0.
  - FILL -> FULL on the handshake that accepts beat number BEATSPERLINE-1.
  - FULL -> IDLE on LineAccept. If LineAccept && FillReq in the same cycle, go FULL -> FILL directly and latch the new FillStartBeat. No bubble.
- BeatReady = (state==FILL). A beat is accepted when BeatValid && BeatReady. The accepted beat is written into slot FillIdx.
- On each accepted beat: FillIdx = (FillIdx+1) mod BEATSPERLINE (wraps, e.g. 6,7,0,1...); counter increments.
- Done is determined by the counter, not by FillIdx.
- LineValid = (state==FULL). It is registered, so it rises the cycle after the last beat is accepted.
- LineData is stable from LineValid rise until acceptance. Slots not yet written during FILL hold stale data; consumers must qualify with LineValid.
- FillReq in FILL, or in FULL without LineAccept, is ignored; the requester must hold it.
- LineAccept outside FULL is ignored.
- BeatValid outside FILL is ignored: no write, no index change.
- Latency: BEATSPERLINE accepted beats + 1 cycle from the first beat to LineValid. With back-to-back beats, that is BEATSPERLINE+1 cycles after entering FILL.
- Reset asserted mid-fill: immediate return to IDLE; the partial line is discarded.

Optional Feature:
Macro: CACHE_FILL_CRITWORD_EN.
- Enabled: adds outputs CritValid (1) and CritData (BEATLEN).
  - CritValid pulses for exactly one cycle, combinationally with the handshake that accepts the first beat of a fill.
  - CritData = BeatData in that cycle. This lets the LSU/IFU consume the missed word early.
- Disabled: the ports are absent, and the consumer waits for LineValid.
- Core state machine timing is identical in both cases.

Decomposition:
- Package cachefill_pkg holds:
  - typedef enum logic [1:0] {FILL_IDLE, FILL_BUSY, FILL_FULL} fillstate_t
  - a function computing IDXW from LINELEN/BEATLEN.
- One sub-module, fill_beat_counter:
  - loadable wrapping index (FillIdx) plus a terminal-count counter
  - inputs: load, start value, increment
  - outputs: index, last.
- Data storage and the FSM stay in the top module.

Test Plan:
1. Reset, then FillReq with FillStartBeat=0. Beats 0x0..0x7 (BEATLEN=64, LINELEN=512) back-to-back -> LineValid at cycle 9; LineData[63:0]=0x0, [511:448]=0x7.
2. FillStartBeat=5, beats A5,A6,A7,A0..A4 -> FillIdx sequence 5,6,7,0,1,2,3,4; slot i holds Ai; LineValid after the 8th beat.
3. BeatValid toggled 1,0,1,0 in FILL -> only asserted cycles are written; FillIdx does not advance on 0 cycles; LineValid after 8 accepted beats.
4. In FULL, assert LineAccept and FillReq (start=2) together -> the next cycle is FILL with FillIdx=2, LineValid=0, no IDLE cycle. FillReq while in FILL -> ignored, state unchanged.
5. Drop reset_n after 3 beats -> immediately BeatReady=0, LineValid=0, Busy=0. After release, a new fill completes correctly with no stale count.
6. CACHE_FILL_CRITWORD_EN=1, start=3, first beat 0xDEAD -> CritValid=1 for exactly that cycle with CritData=0xDEAD; no pulse on later beats.
